// File: rtl/chacha_block_core_pkg.sv
// Shared definitions for the ChaCha block core: word width, sigma constants,
// quarter-round word index tables and FSM state encoding.
package chacha_block_core_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam word_t SIGMA [0:3] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  // Row q lists the (a,b,c,d) state words fed to quarter-round instance q.
  localparam logic [3:0] QR_COL [0:3][0:3] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] QR_DIAG [0:3][0:3] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t rotl(word_t v, int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_block_core_qr.sv
// chacha_qr_comb: one purely combinational ChaCha quarter round.
module chacha_qr_comb
  import chacha_block_core_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  logic [31:0] w_a1, w_b1, w_c1, w_d1;
  logic [31:0] w_a2, w_b2, w_c2, w_d2;

  assign w_a1 = i_a + i_b;
  assign w_d1 = rotl(i_d ^ w_a1, 16);
  assign w_c1 = i_c + w_d1;
  assign w_b1 = rotl(i_b ^ w_c1, 12);
  assign w_a2 = w_a1 + w_b1;
  assign w_d2 = rotl(w_d1 ^ w_a2, 8);
  assign w_c2 = w_c1 + w_d2;
  assign w_b2 = rotl(w_b1 ^ w_c2, 7);

  assign o_a = w_a2;
  assign o_b = w_b2;
  assign o_c = w_c2;
  assign o_d = w_d2;

endmodule

// File: rtl/chacha_block_core.sv
// ChaCha block-function sequencer: one column/diagonal round per cycle, start/valid handshake.
// Optional build macro CHACHA_BACK2BACK_EN chains the next counter block straight from OUT.
module chacha_block_core
  import chacha_block_core_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  blk_cnt,
  output logic [511:0] ks_data,
  output logic         ks_valid,
  input  logic         ks_ready
);

  localparam int RND_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  state_t             r_state, w_state_nxt;
  logic [RND_W-1:0]   r_rnd;
  logic [15:0][31:0]  r_x, r_s, r_ks;
  logic [15:0][31:0]  w_init, w_round, w_final;
  logic [31:0]        w_col_res  [0:15];
  logic [31:0]        w_diag_res [0:15];
  logic [31:0]        w_qr_in    [0:3][0:3];
  logic [31:0]        w_qr_out   [0:3][0:3];
  logic               w_last;

  assign w_init = {nonce, blk_cnt, key, SIGMA[3], SIGMA[2], SIGMA[1], SIGMA[0]};
  assign w_last = (r_rnd == RND_W'(ROUNDS - 1));

  // Four quarter rounds share inputs via the column/diagonal index tables.
  for (genvar q = 0; q < 4; q++) begin : g_qr
    for (genvar j = 0; j < 4; j++) begin : g_word
      assign w_qr_in[q][j] = r_rnd[0] ? r_x[QR_DIAG[q][j]] : r_x[QR_COL[q][j]];
      assign w_col_res[QR_COL[q][j]]   = w_qr_out[q][j];
      assign w_diag_res[QR_DIAG[q][j]] = w_qr_out[q][j];
    end
    chacha_qr_comb u_qr (
      .i_a (w_qr_in[q][0]),
      .i_b (w_qr_in[q][1]),
      .i_c (w_qr_in[q][2]),
      .i_d (w_qr_in[q][3]),
      .o_a (w_qr_out[q][0]),
      .o_b (w_qr_out[q][1]),
      .o_c (w_qr_out[q][2]),
      .o_d (w_qr_out[q][3])
    );
  end

  for (genvar i = 0; i < 16; i++) begin : g_state
    assign w_round[i] = r_rnd[0] ? w_diag_res[i] : w_col_res[i];
    assign w_final[i] = r_x[i] + r_s[i];
  end

`ifdef CHACHA_BACK2BACK_EN
  logic [15:0][31:0] w_next_init;
  assign w_next_init = {r_s[15:13], r_s[12] + 32'd1, r_s[11:0]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ROUND;
      ST_ROUND: if (w_last) w_state_nxt = ST_FINAL;
      ST_FINAL: w_state_nxt = ST_OUT;
      ST_OUT: begin
`ifdef CHACHA_BACK2BACK_EN
        if (ks_ready) w_state_nxt = start ? ST_ROUND : ST_IDLE;
`else
        if (ks_ready) w_state_nxt = ST_IDLE;
`endif
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (r_state == ST_IDLE);
    ks_valid = (r_state == ST_OUT);
    ks_data  = r_ks;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x   <= '0;
      r_s   <= '0;
      r_ks  <= '0;
      r_rnd <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_x   <= w_init;
          r_s   <= w_init;
          r_rnd <= '0;
        end
        ST_ROUND: begin
          r_x   <= w_round;
          r_rnd <= r_rnd + 1'b1;
        end
        ST_FINAL: r_ks <= w_final;
        ST_OUT: begin
`ifdef CHACHA_BACK2BACK_EN
          if (ks_ready && start) begin
            r_x   <= w_next_init;
            r_s   <= w_next_init;
            r_rnd <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core against a plain-array ChaCha block model.
module tb_chacha_block_core;

  localparam int ROUNDS = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         ready;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  blk_cnt = '0;
  logic [511:0] ks_data;
  logic         ks_valid;
  logic         ks_ready = 1'b0;

  logic [31:0]  qa, qb, qc, qd, qoa, qob, qoc, qod;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chacha_block_core #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ready    (ready),
    .key      (key),
    .nonce    (nonce),
    .blk_cnt  (blk_cnt),
    .ks_data  (ks_data),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready)
  );

  chacha_qr_comb u_qr_unit (
    .i_a (qa), .i_b (qb), .i_c (qc), .i_d (qd),
    .o_a (qoa), .o_b (qob), .o_c (qoc), .o_d (qod)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    int a, b, cc, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int rr = 0; rr < ROUNDS; rr++) begin
      for (int i = 0; i < 4; i++) begin
        a = i;
        if (rr % 2 == 0) begin
          b = 4 + i; cc = 8 + i; d = 12 + i;
        end else begin
          b = 4 + (i + 1) % 4; cc = 8 + (i + 2) % 4; d = 12 + (i + 3) % 4;
        end
        x[a] = x[a] + x[b];  x[d] = rl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b];  x[d] = rl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           output logic [511:0] data, output int lat);
    key = k; nonce = n; blk_cnt = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!ks_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!ks_valid) check("valid_timeout", 1'b0, 1'b1);
    data = ks_data;
  endtask

  task automatic handshake();
    ks_ready = 1'b1;
    tick();
    ks_ready = 1'b0;
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  logic [255:0] rfc_key, k2;
  logic [95:0]  rfc_nonce, n2;
  logic [31:0]  c2;
  logic [511:0] got, snap, blk0, blk1;
  int           lat, t0, t1, nblk;
  logic         stable;

  initial begin
    for (int i = 0; i < 8; i++) rfc_key[32*i +: 32] = 32'h03020100 + 32'h04040404 * i;
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    // reset state
    tick(); tick();
    check("rst_ready", ready, 1'b1);
    check("rst_valid", ks_valid, 1'b0);
    check("rst_data", ks_data, '0);
    rst = 1'b1;
    tick();

    // quarter-round unit vector
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    check("qr_a", qoa, 32'hea2a92f4);
    check("qr_b", qob, 32'hcb1cf8ce);
    check("qr_c", qoc, 32'h4581472e);
    check("qr_d", qod, 32'h5881c4bb);

    // RFC block vector
    run_block(rfc_key, rfc_nonce, 32'd1, got, lat);
    check("rfc_latency", lat, ROUNDS + 2);
    check("rfc_w0", got[31:0], 32'he4e7f110);
    check("rfc_w1", got[63:32], 32'h15593bd1);
    check("rfc_w15", got[511:480], 32'h4e3c50a2);
    check("rfc_full", got, ref_block(rfc_key, rfc_nonce, 32'd1));
    handshake();
    check("post_hs_ready", ready, 1'b1);
    check("post_hs_valid", ks_valid, 1'b0);

    // random blocks with random downstream delay
    for (int it = 0; it < 6; it++) begin
      k2 = rand_key();
      n2 = {$urandom, $urandom, $urandom};
      c2 = $urandom;
      run_block(k2, n2, c2, got, lat);
      repeat ($urandom_range(0, 3)) tick();
      check("rand_block", ks_data, ref_block(k2, n2, c2));
      check("rand_latency", lat, ROUNDS + 2);
      handshake();
    end

    // counter at all-ones: no carry into nonce
    k2 = rand_key();
    n2 = {$urandom, $urandom, $urandom};
    run_block(k2, n2, 32'hFFFFFFFF, got, lat);
    snap = ref_block(k2, n2, 32'hFFFFFFFF);
    check("cnt_max_w12", got[32*12 +: 32], snap[32*12 +: 32]);
    check("cnt_max_full", got, snap);
    handshake();

    // backpressure with an ignored start
    k2 = rand_key();
    n2 = {$urandom, $urandom, $urandom};
    c2 = $urandom;
    run_block(k2, n2, c2, snap, lat);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        key = rand_key(); blk_cnt = $urandom; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (ks_data !== snap || ready !== 1'b0 || ks_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_data", snap, ref_block(k2, n2, c2));
    handshake();
    check("bp_release_valid", ks_valid, 1'b0);
    check("bp_release_ready", ready, 1'b1);
    repeat (5) tick();
    check("bp_not_queued", {ks_valid, ready}, 2'b01);

    // reset mid-block
    key = rand_key(); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    #2;
    check("mid_rst_valid", ks_valid, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_data", ks_data, '0);
    #2;
    rst = 1'b1;
    tick();
    k2 = rand_key();
    n2 = {$urandom, $urandom, $urandom};
    c2 = $urandom;
    run_block(k2, n2, c2, got, lat);
    check("after_rst_block", got, ref_block(k2, n2, c2));
    check("after_rst_latency", lat, ROUNDS + 2);
    handshake();

`ifdef CHACHA_BACK2BACK_EN
    // back-to-back chaining from the stored state
    key = rfc_key; nonce = rfc_nonce; blk_cnt = 32'd1;
    start = 1'b1; ks_ready = 1'b1;
    nblk = 0; t0 = 0; t1 = 0;
    for (int t = 1; t <= 100 && nblk < 2; t++) begin
      tick();
      if (ks_valid) begin
        if (nblk == 0) begin blk0 = ks_data; t0 = t; end
        else           begin blk1 = ks_data; t1 = t; start = 1'b0; end
        nblk++;
      end
    end
    start = 1'b0;
    check("b2b_count", nblk, 2);
    check("b2b_blk0", blk0, ref_block(rfc_key, rfc_nonce, 32'd1));
    check("b2b_blk1", blk1, ref_block(rfc_key, rfc_nonce, 32'd2));
    check("b2b_spacing", t1 - t0, ROUNDS + 2);
    tick(); tick();
    ks_ready = 1'b0;
    check("b2b_idle", ready, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
